// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - BIST read-response analyzer with fail log
//
// Purpose:
//   Receive-side companion to the BIST pattern generators. Delays the
//   generator's expected read stream by the SRAM read latency, compares it
//   against SRAM read data, and reports a sticky pass/fail flag, a saturating
//   mismatch count and a small FIFO log of failing {addr, expected, observed}.
//
// Ports:
//   clk            clock, all state on posedge
//   rst            synchronous reset, active-low
//   test_start_i   1-cycle pulse: clear results, begin analysis
//   exp_valid_i    generator issues a read this cycle
//   exp_addr_i     address of that read
//   exp_data_i     expected data for that read
//   gen_done_i     generator finished (sampled in RUN only)
//   rd_data_i      SRAM read data
//   pass_or_fail_o 1 = no mismatch since test_start, 0 = fail (sticky)
//   fail_count_o   mismatches since test_start, saturating
//   analysis_done_o high in DONE state
//   log_valid_o    fail-log head entry available
//   log_ready_i    consumer accepts head entry
//   log_addr_o     head entry address
//   log_exp_o      head entry expected data
//   log_obs_o      head entry observed data
//   log_overflow_o sticky: a mismatch was dropped because the log was full

module bist_response_analyzer #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 2,
  parameter int READ_LATENCY = 1,
  parameter int LOG_DEPTH    = 4,
  parameter int CNT_W        = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_start_i,
  input  logic              exp_valid_i,
  input  logic [ADDR_W-1:0] exp_addr_i,
  input  logic [DATA_W-1:0] exp_data_i,
  input  logic              gen_done_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              pass_or_fail_o,
  output logic [CNT_W-1:0]  fail_count_o,
  output logic              analysis_done_o,
  output logic              log_valid_o,
  input  logic              log_ready_i,
  output logic [ADDR_W-1:0] log_addr_o,
  output logic [DATA_W-1:0] log_exp_o,
  output logic [DATA_W-1:0] log_obs_o,
  output logic              log_overflow_o
);

  localparam int PTR_W  = $clog2(LOG_DEPTH);
  localparam int DCNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic drain_last;
  logic in_run, in_active;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign drain_last = (drain_cnt_q == DCNT_W'(READ_LATENCY - 1));

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        if (gen_done_i) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        // The last read was issued at or before the gen_done cycle, so
        // READ_LATENCY drain cycles bring it out of the pipeline.
        if (drain_last) state_d = S_DONE;
        else            drain_cnt_d = drain_cnt_q + 1'b1;
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
    // test_start restarts from any state
    if (test_start_i) begin
      state_d     = S_RUN;
      drain_cnt_d = '0;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_run          = (state_q == S_RUN);
    in_active       = (state_q == S_RUN) || (state_q == S_DRAIN);
    analysis_done_o = (state_q == S_DONE);
  end

  // ---------------- Alignment pipeline ----------------
  logic [READ_LATENCY-1:0] pv_q;
  logic [ADDR_W-1:0]       pa_q [READ_LATENCY];
  logic [DATA_W-1:0]       pd_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst || test_start_i || !in_active) begin
      pv_q <= '0;
    end else begin
      // New reads only enter while RUN; DRAIN just flushes what is in flight.
      pv_q[0] <= in_run && exp_valid_i;
      for (int i = 1; i < READ_LATENCY; i++) pv_q[i] <= pv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pa_q[i] <= '0;
        pd_q[i] <= '0;
      end
    end else begin
      pa_q[0] <= exp_addr_i;
      pd_q[0] <= exp_data_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pa_q[i] <= pa_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  logic mismatch;
  assign mismatch = in_active && !test_start_i && pv_q[READ_LATENCY-1] &&
                    (rd_data_i != pd_q[READ_LATENCY-1]);

  // ---------------- Fail log FIFO ----------------
  logic [ADDR_W-1:0] la_q [LOG_DEPTH];
  logic [DATA_W-1:0] le_q [LOG_DEPTH];
  logic [DATA_W-1:0] lo_q [LOG_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [PTR_W:0]    occ_q;
  logic full, push, pop;

  assign full        = (occ_q == (PTR_W+1)'(LOG_DEPTH));
  assign log_valid_o = (occ_q != '0);
  assign pop         = log_valid_o && log_ready_i && !test_start_i;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign push        = mismatch && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst || test_start_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      la_q[wr_q] <= pa_q[READ_LATENCY-1];
      le_q[wr_q] <= pd_q[READ_LATENCY-1];
      lo_q[wr_q] <= rd_data_i;
    end
  end

  // Head is read from registered storage at a registered pointer, so it is
  // stable while the consumer stalls; forced to zero when the log is empty.
  assign log_addr_o = log_valid_o ? la_q[rd_q] : '0;
  assign log_exp_o  = log_valid_o ? le_q[rd_q] : '0;
  assign log_obs_o  = log_valid_o ? lo_q[rd_q] : '0;

  // ---------------- Results ----------------
  logic              pass_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;

  always_ff @(posedge clk) begin
    if (!rst || test_start_i) begin
      pass_q <= 1'b1;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (mismatch) begin
      pass_q <= 1'b0;
      if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (full && !pop) ovf_q <= 1'b1;
    end
  end

  assign pass_or_fail_o = pass_q;
  assign fail_count_o   = cnt_q;
  assign log_overflow_o = ovf_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - directed bench for bist_response_analyzer

module tb_bist_response_analyzer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---- DUT A: READ_LATENCY=1, CNT_W=6 ----
  logic       ts_a, ev_a, gd_a, lr_a;
  logic [3:0] ea_a;
  logic [1:0] ed_a, obs_a, rd_a;
  logic       pf_a, dn_a, lv_a, ovf_a;
  logic [5:0] fc_a;
  logic [3:0] la_a;
  logic [1:0] le_a, lo_a;

  bist_response_analyzer #(.ADDR_W(4), .DATA_W(2), .READ_LATENCY(1), .LOG_DEPTH(4), .CNT_W(6)) u_a (
    .clk(clk), .rst(rst), .test_start_i(ts_a), .exp_valid_i(ev_a), .exp_addr_i(ea_a),
    .exp_data_i(ed_a), .gen_done_i(gd_a), .rd_data_i(rd_a), .pass_or_fail_o(pf_a),
    .fail_count_o(fc_a), .analysis_done_o(dn_a), .log_valid_o(lv_a), .log_ready_i(lr_a),
    .log_addr_o(la_a), .log_exp_o(le_a), .log_obs_o(lo_a), .log_overflow_o(ovf_a)
  );

  // SRAM stand-in: returns the bench-chosen observed value one cycle later
  always @(posedge clk) rd_a <= obs_a;

  // ---- DUT B: READ_LATENCY=2, CNT_W=2 ----
  logic       ts_b, ev_b, gd_b, lr_b;
  logic [3:0] ea_b;
  logic [1:0] ed_b, obs_b, d1_b, rd_b;
  logic       pf_b, dn_b, lv_b, ovf_b;
  logic [1:0] fc_b;
  logic [3:0] la_b;
  logic [1:0] le_b, lo_b;

  bist_response_analyzer #(.ADDR_W(4), .DATA_W(2), .READ_LATENCY(2), .LOG_DEPTH(4), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .test_start_i(ts_b), .exp_valid_i(ev_b), .exp_addr_i(ea_b),
    .exp_data_i(ed_b), .gen_done_i(gd_b), .rd_data_i(rd_b), .pass_or_fail_o(pf_b),
    .fail_count_o(fc_b), .analysis_done_o(dn_b), .log_valid_o(lv_b), .log_ready_i(lr_b),
    .log_addr_o(la_b), .log_exp_o(le_b), .log_obs_o(lo_b), .log_overflow_o(ovf_b)
  );

  always @(posedge clk) begin
    d1_b <= obs_b;
    rd_b <= d1_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_a(input logic [3:0] a, input logic [1:0] e, input logic [1:0] o);
    ev_a = 1'b1; ea_a = a; ed_a = e; obs_a = o;
    step();
    ev_a = 1'b0; obs_a = 2'b00;
  endtask

  task automatic read_b(input logic [3:0] a, input logic [1:0] e, input logic [1:0] o);
    ev_b = 1'b1; ea_b = a; ed_b = e; obs_b = o;
    step();
    ev_b = 1'b0; obs_b = 2'b00;
  endtask

  task automatic start_a();
    ts_a = 1'b1; step(); ts_a = 1'b0;
  endtask

  task automatic start_b();
    ts_b = 1'b1; step(); ts_b = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ts_a = 0; ev_a = 0; gd_a = 0; lr_a = 0; ea_a = 0; ed_a = 0; obs_a = 0;
    ts_b = 0; ev_b = 0; gd_b = 0; lr_b = 0; ea_b = 0; ed_b = 0; obs_b = 0;
    step(); step();

    // Reset state
    check("rst_pass", pf_a, 1);
    check("rst_count", fc_a, 0);
    check("rst_done", dn_a, 0);
    check("rst_log_valid", lv_a, 0);
    check("rst_log_addr", la_a, 0);
    check("rst_overflow", ovf_a, 0);
    rst = 1'b1;
    step();

    // Fault-free run; a mismatching read on the test_start cycle is ignored
    ts_a = 1'b1; ev_a = 1'b1; ea_a = 4'hF; ed_a = 2'b01; obs_a = 2'b10;
    step();
    ts_a = 1'b0; ev_a = 1'b0; obs_a = 2'b00;
    for (int i = 0; i < 16; i++) begin
      read_a(4'(i), (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    gd_a = 1'b1; step(); gd_a = 1'b0;
    check("ff_done_early", dn_a, 0);
    step();
    check("ff_done", dn_a, 1);
    check("ff_pass", pf_a, 1);
    check("ff_count", fc_a, 0);
    check("ff_log_valid", lv_a, 0);

    // Single fault at addr 5
    start_a();
    check("sf_not_done", dn_a, 0);
    read_a(4'h5, 2'b01, 2'b11);
    check("sf_pass_before", pf_a, 1);
    step();
    check("sf_pass", pf_a, 0);
    check("sf_count", fc_a, 1);
    check("sf_log_valid", lv_a, 1);
    check("sf_log_addr", la_a, 4'h5);
    check("sf_log_exp", le_a, 2'b01);
    check("sf_log_obs", lo_a, 2'b11);
    lr_a = 1'b1; step(); lr_a = 1'b0;
    check("sf_popped", lv_a, 0);
    gd_a = 1'b1; step(); gd_a = 1'b0;
    step();
    check("sf_done", dn_a, 1);
    step(); step();
    check("sf_hold_count", fc_a, 1);
    check("sf_hold_pass", pf_a, 0);

    // Overflow: 6 mismatches with no consumer
    start_a();
    for (int i = 0; i < 6; i++) read_a(4'(i), 2'b00, 2'b11);
    step();
    check("ov_count", fc_a, 6);
    check("ov_flag", ovf_a, 1);
    for (int i = 0; i < 4; i++) begin
      check("ov_log_order", la_a, i);
      lr_a = 1'b1; step(); lr_a = 1'b0;
    end
    check("ov_log_empty", lv_a, 0);
    check("ov_flag_sticky", ovf_a, 1);

    // Push+pop while full on the 5th mismatch: no overflow
    start_a();
    check("pp_ovf_cleared", ovf_a, 0);
    for (int i = 0; i < 5; i++) read_a(4'(i), 2'b00, 2'b11);
    lr_a = 1'b1; step(); lr_a = 1'b0;
    check("pp_no_overflow", ovf_a, 0);
    check("pp_count", fc_a, 5);
    for (int i = 1; i < 5; i++) begin
      check("pp_log_order", la_a, i);
      lr_a = 1'b1; step(); lr_a = 1'b0;
    end
    check("pp_log_empty", lv_a, 0);

    // Reset mid-RUN with 2 logged fails
    start_a();
    read_a(4'h7, 2'b01, 2'b10);
    read_a(4'h8, 2'b10, 2'b01);
    step();
    check("ab_count_pre", fc_a, 2);
    check("ab_log_pre", lv_a, 1);
    rst = 1'b0; step(); rst = 1'b1;
    check("ab_pass", pf_a, 1);
    check("ab_count", fc_a, 0);
    check("ab_log_valid", lv_a, 0);
    check("ab_log_addr", la_a, 0);
    check("ab_done", dn_a, 0);
    check("ab_overflow", ovf_a, 0);
    read_a(4'h9, 2'b01, 2'b10);
    step();
    check("idle_ignores_reads", fc_a, 0);

    // test_start from DONE with fail_count=3
    start_a();
    read_a(4'h1, 2'b01, 2'b00);
    read_a(4'h2, 2'b01, 2'b00);
    read_a(4'h3, 2'b01, 2'b00);
    gd_a = 1'b1; step(); gd_a = 1'b0;
    step();
    check("dn_done", dn_a, 1);
    check("dn_count", fc_a, 3);
    check("dn_log_head", la_a, 4'h1);
    start_a();
    check("rs_count", fc_a, 0);
    check("rs_pass", pf_a, 1);
    check("rs_log_valid", lv_a, 0);
    check("rs_done", dn_a, 0);
    read_a(4'h2, 2'b01, 2'b00);
    step();
    check("rs_running", fc_a, 1);

    // DUT B: saturation at CNT_W=2
    start_b();
    for (int i = 0; i < 5; i++) read_b(4'(i), 2'b01, 2'b10);
    step(); step();
    check("sat_count", fc_b, 2'b11);
    check("sat_pass", pf_b, 0);

    // DUT B: mismatch on the last read issued with gen_done, READ_LATENCY=2
    start_b();
    read_b(4'h0, 2'b01, 2'b01);
    ev_b = 1'b1; ea_b = 4'hA; ed_b = 2'b10; obs_b = 2'b01; gd_b = 1'b1;
    step();
    ev_b = 1'b0; obs_b = 2'b00; gd_b = 1'b0;
    check("lat_drain1_done", dn_b, 0);
    step();
    check("lat_drain2_done", dn_b, 0);
    step();
    check("lat_done", dn_b, 1);
    check("lat_count", fc_b, 1);
    check("lat_log_valid", lv_b, 1);
    check("lat_log_addr", la_b, 4'hA);
    check("lat_log_exp", le_b, 2'b10);
    check("lat_log_obs", lo_b, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
